// File: rtl/max7219_rx_if.sv
// MAX7219 serial pin bundle (LOAD/CS, serial clock, serial data) as seen at the FPGA boundary.
// The host side drives the pins; the receiver only observes them.
interface max7219_rx_if;
  logic max_cs;
  logic max_clk;
  logic max_din;

  modport master (output max_cs, output max_clk, output max_din);
  modport slave  (input  max_cs, input  max_clk, input  max_din);
endinterface

// File: rtl/max7219_rx.sv
// Receiver for daisy-chained MAX7219 command words: decodes them into per-device registers and a frame buffer.
// Optional MAX7219_STATS_EN adds frame_count/err_count statistics ports.
module max7219_rx #(
  parameter int NUM_DEV = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  max7219_rx_if.slave                   pins,
  input  logic [$clog2(NUM_DEV*8)-1:0]  rd_addr,
  output logic [7:0]                    rd_data,
  output logic                          frame_strobe,
  output logic [NUM_DEV-1:0]            shutdown_n,
  output logic [NUM_DEV-1:0]            disp_test,
  output logic [4*NUM_DEV-1:0]          intensity
`ifdef MAX7219_STATS_EN
  ,
  output logic [15:0]                   frame_count,
  output logic [7:0]                    err_count
`endif
);

  localparam int ROWS  = NUM_DEV * 8;
  localparam int ROW_W = $clog2(ROWS);
  localparam int WC_W  = $clog2(NUM_DEV + 1);
  localparam int SR_W  = 16 * NUM_DEV;

  // Stage [0],[1] synchronise; stage [2] is the previous value for edge detection.
  logic [2:0]        cs_sync;
  logic [2:0]        sclk_sync;
  logic [1:0]        din_sync;
  logic [3:0]        bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [SR_W-1:0]   shreg;
  logic [7:0]        frame [ROWS];

  logic [7:0]        frame_nxt [ROWS];
  logic [NUM_DEV-1:0]   shdn_nxt;
  logic [NUM_DEV-1:0]   test_nxt;
  logic [4*NUM_DEV-1:0] int_nxt;
  logic [15:0]       wrd;

  logic cs_fall, cs_rise, sclk_rise, frame_valid;

  assign cs_fall     =  cs_sync[2] & ~cs_sync[1];
  assign cs_rise     = ~cs_sync[2] &  cs_sync[1];
  assign sclk_rise   = ~sclk_sync[2] & sclk_sync[1];
  assign frame_valid = (bit_cnt == 4'd0) && (word_cnt != '0);

  // Register image after a commit: devices below word_cnt take their word, the rest keep state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    frame_nxt = frame;
    shdn_nxt  = shutdown_n;
    test_nxt  = disp_test;
    int_nxt   = intensity;
    wrd       = '0;
    for (int d = 0; d < NUM_DEV; d++) begin
      wrd = shreg[16*d +: 16];
      if (d < int'(word_cnt)) begin
        case (wrd[11:8])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
            frame_nxt[ROW_W'(d*8 + int'(wrd[11:8]) - 1)] = wrd[7:0];
          4'hA:    int_nxt[4*d +: 4] = wrd[3:0];
          4'hC:    shdn_nxt[d]       = wrd[0];
          4'hF:    test_nxt[d]       = wrd[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync      <= '1;
      sclk_sync    <= '0;
      din_sync     <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shreg        <= '0;
      frame_strobe <= 1'b0;
      shutdown_n   <= '0;
      disp_test    <= '0;
      intensity    <= '0;
      rd_data      <= '0;
      // NOTE: the frame must read back as zero after reset, so it is built from resettable flops, not RAM.
      for (int r = 0; r < ROWS; r++) frame[r] <= '0;
`ifdef MAX7219_STATS_EN
      frame_count  <= '0;
      err_count    <= '0;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
      cs_sync      <= {cs_sync[1:0],   pins.max_cs};
      sclk_sync    <= {sclk_sync[1:0], pins.max_clk};
      din_sync     <= {din_sync[0],    pins.max_din};
      frame_strobe <= 1'b0;

      if (cs_fall) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (sclk_rise && !cs_sync[1]) begin
        shreg   <= {shreg[SR_W-2:0], din_sync[1]};
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15 && word_cnt != WC_W'(NUM_DEV))
          word_cnt <= word_cnt + WC_W'(1);
      end

      if (cs_rise && frame_valid) begin
        frame        <= frame_nxt;
        shutdown_n   <= shdn_nxt;
        disp_test    <= test_nxt;
        intensity    <= int_nxt;
        frame_strobe <= 1'b1;
`ifdef MAX7219_STATS_EN
        frame_count  <= frame_count + 16'd1;
`endif
      end
`ifdef MAX7219_STATS_EN
      else if (cs_rise) begin
        err_count <= err_count + 8'd1;
      end
`endif

      rd_data <= (32'(rd_addr) < ROWS) ? frame[rd_addr] : 8'h00;
    end
  end

endmodule
